// File: rtl/psw_ctx_pkg.sv
// Shared 8051 PSW constants: SFR addresses, ALU flag-update modes and PSW bit positions.
package psw_ctx_pkg;

  localparam logic [7:0] SFR_PSW   = 8'hD0;
  localparam logic [4:0] SFR_B_PSW = 5'h1A;

  localparam logic [1:0] FLAG_NONE    = 2'b00;
  localparam logic [1:0] CY_SET       = 2'b01;
  localparam logic [1:0] CY_OV_SET    = 2'b10;
  localparam logic [1:0] CY_OV_AC_SET = 2'b11;

  localparam int unsigned PSW_CY  = 7;
  localparam int unsigned PSW_AC  = 6;
  localparam int unsigned PSW_F0  = 5;
  localparam int unsigned PSW_RS1 = 4;
  localparam int unsigned PSW_RS0 = 3;
  localparam int unsigned PSW_OV  = 2;
  localparam int unsigned PSW_F1  = 1;
  localparam int unsigned PSW_P   = 0;

endpackage

// File: rtl/psw_ctx_stack.sv
// LIFO of saved PSW images. Push and pop in the same cycle, push when full or pop when
// empty are all dropped and flagged on the err_o strobe.
module psw_ctx_stack #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              pop_ok_o,
  output logic              err_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d, count_m1;
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic              push_ok;

  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;

  assign push_ok  = push_i & ~pop_i & ~full_o;
  assign pop_ok_o = pop_i & ~push_i & ~empty_o;
  assign err_o    = (push_i & pop_i) | (push_i & full_o) | (pop_i & empty_o);

  assign count_m1 = count_q - CNT_W'(1);
  assign wr_ptr   = count_q[PtrW-1:0];
  assign rd_ptr   = count_m1[PtrW-1:0];
  assign rdata_o  = mem_q[rd_ptr];

  always_comb begin
    count_d = count_q;
    if (push_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok_o) begin
      count_d = count_m1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Slots carry no reset; unoccupied contents are never observed.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr] <= wdata_i;
    end
  end

endmodule

// File: rtl/psw_ctx.sv
// 8051 program status word with a hardware context stack for interrupt entry/RETI.
// Owns the live PSW register, the write-source priority and the sticky stack error.
module psw_ctx
  import psw_ctx_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              carry_in,
  input  logic              aux_carry_in,
  input  logic              overflow_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] acc_in,
  input  logic [7:0]        addr,
  input  logic              write_en,
  input  logic              write_bit_en,
  input  logic [1:0]        flag_set,
  input  logic              push,
  input  logic              pop,
  input  logic              clear_err,
  output logic [DATA_W-1:0] psw_data,
  output logic [CNT_W-1:0]  depth_cnt,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  logic [DATA_W-1:0] psw_q, psw_d;
  logic [DATA_W-1:0] stack_rdata;
  logic              err_q, err_d;
  logic              pop_ok, err_strobe;
  logic              byte_wr, bit_wr;

  psw_ctx_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_stack (
    .clock    (clock),
    .reset    (reset),
    .push_i   (push),
    .pop_i    (pop),
    .wdata_i  (psw_q),
    .rdata_o  (stack_rdata),
    .count_o  (depth_cnt),
    .full_o   (stack_full),
    .empty_o  (stack_empty),
    .pop_ok_o (pop_ok),
    .err_o    (err_strobe)
  );

  assign byte_wr = write_en & ~write_bit_en & (addr == SFR_PSW);
  assign bit_wr  = write_en & write_bit_en & (addr[7:3] == SFR_B_PSW);

  always_comb begin
    psw_d = psw_q;
    if (pop_ok) begin
      psw_d[DATA_W-1:1] = stack_rdata[DATA_W-1:1];
    end else if (byte_wr) begin
      psw_d[DATA_W-1:1] = data_in[DATA_W-1:1];
    end else if (bit_wr) begin
      // Bit 0 is parity and cannot be written; the write is swallowed.
      if (addr[2:0] != 3'd0) begin
        psw_d[addr[2:0]] = carry_in;
      end
    end else begin
      unique case (flag_set)
        FLAG_NONE: ;
        CY_SET: psw_d[PSW_CY] = carry_in;
        CY_OV_SET: begin
          psw_d[PSW_CY] = carry_in;
          psw_d[PSW_OV] = overflow_in;
        end
        CY_OV_AC_SET: begin
          psw_d[PSW_CY] = carry_in;
          psw_d[PSW_OV] = overflow_in;
          psw_d[PSW_AC] = aux_carry_in;
        end
      endcase
    end
    psw_d[PSW_P] = ^acc_in;
  end

  always_comb begin
    err_d = err_q;
    if (err_strobe) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      psw_q <= '0;
      err_q <= 1'b0;
    end else begin
      psw_q <= psw_d;
      err_q <= err_d;
    end
  end

  assign psw_data  = psw_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_psw_ctx.sv
// Directed bench for psw_ctx: flag sources, write priority, context stack and async reset.
module tb_psw_ctx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       carry_in = 1'b0, aux_carry_in = 1'b0, overflow_in = 1'b0;
  logic [7:0] data_in = '0, acc_in = '0, addr = '0;
  logic       write_en = 1'b0, write_bit_en = 1'b0;
  logic [1:0] flag_set = 2'b00;
  logic       push = 1'b0, pop = 1'b0, clear_err = 1'b0;
  logic [7:0] psw_data;
  logic [2:0] depth_cnt;
  logic       stack_full, stack_empty, stack_err;

  int total = 0;
  int bad   = 0;

  psw_ctx #(
    .DATA_W (8),
    .DEPTH  (4),
    .CNT_W  (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .carry_in     (carry_in),
    .aux_carry_in (aux_carry_in),
    .overflow_in  (overflow_in),
    .data_in      (data_in),
    .acc_in       (acc_in),
    .addr         (addr),
    .write_en     (write_en),
    .write_bit_en (write_bit_en),
    .flag_set     (flag_set),
    .push         (push),
    .pop          (pop),
    .clear_err    (clear_err),
    .psw_data     (psw_data),
    .depth_cnt    (depth_cnt),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .stack_err    (stack_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_en = 0; write_bit_en = 0; flag_set = 2'b00;
    push = 0; pop = 0; clear_err = 0; carry_in = 0; aux_carry_in = 0; overflow_in = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_psw"}, 32'(psw_data), 32'h00);
    chk({tag, "_cnt"}, 32'(depth_cnt), 32'd0);
    chk({tag, "_empty"}, 32'(stack_empty), 32'd1);
    chk({tag, "_full"}, 32'(stack_full), 32'd0);
    chk({tag, "_err"}, 32'(stack_err), 32'd0);
  endtask

  initial begin
    #2 reset = 1;
    #2 chk_reset("rst");
    @(posedge clock); #1 reset = 0;

    acc_in = 8'h07; tick();
    chk("parity", 32'(psw_data), 32'h01);
    chk("parity_empty", 32'(stack_empty), 32'd1);
    chk("parity_cnt", 32'(depth_cnt), 32'd0);

    acc_in = 8'h00; write_en = 1; addr = 8'hD0; data_in = 8'hFF; tick();
    chk("byte_wr", 32'(psw_data), 32'hFE);
    write_bit_en = 1; addr = 8'hD7; carry_in = 0; tick();
    chk("bit_wr_cy", 32'(psw_data), 32'h7E);
    addr = 8'hD0; carry_in = 1; tick();
    chk("bit_wr_p", 32'(psw_data), 32'h7E);

    write_bit_en = 0; data_in = 8'h40; tick();
    chk("byte_wr_40", 32'(psw_data), 32'h40);
    write_en = 0; flag_set = 2'b11; carry_in = 1; overflow_in = 1; aux_carry_in = 0; tick();
    chk("flags_11", 32'(psw_data), 32'h84);
    write_en = 1; data_in = 8'h18; tick();
    chk("wr_over_flags", 32'(psw_data), 32'h18);

    idle(); push = 1; flag_set = 2'b01; carry_in = 1; tick();
    chk("push_live", 32'(psw_data), 32'h98);
    chk("push_cnt", 32'(depth_cnt), 32'd1);
    idle(); pop = 1; tick();
    chk("pop_live", 32'(psw_data), 32'h18);
    chk("pop_cnt", 32'(depth_cnt), 32'd0);
    chk("pop_err", 32'(stack_err), 32'd0);

    // Five pushes; each also byte-writes the next image so the stack holds 18,20,30,40.
    idle(); push = 1; write_en = 1; addr = 8'hD0;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'h20 + 8'(i * 16);
      tick();
    end
    idle();
    chk("full_cnt", 32'(depth_cnt), 32'd4);
    chk("full_flag", 32'(stack_full), 32'd1);
    chk("full_err", 32'(stack_err), 32'd1);
    chk("full_live", 32'(psw_data), 32'h60);

    clear_err = 1; tick(); idle();
    chk("clear_err", 32'(stack_err), 32'd0);

    pop = 1;
    tick(); chk("pop1", 32'(psw_data), 32'h40); chk("pop1_cnt", 32'(depth_cnt), 32'd3);
    tick(); chk("pop2", 32'(psw_data), 32'h30);
    tick(); chk("pop3", 32'(psw_data), 32'h20);
    tick(); chk("pop4", 32'(psw_data), 32'h18); chk("pop4_empty", 32'(stack_empty), 32'd1);
    chk("pop4_err", 32'(stack_err), 32'd0);
    tick(); chk("pop5_live", 32'(psw_data), 32'h18); chk("pop5_err", 32'(stack_err), 32'd1);
    chk("pop5_cnt", 32'(depth_cnt), 32'd0);
    clear_err = 1; tick();
    chk("set_wins", 32'(stack_err), 32'd1);
    idle(); clear_err = 1; tick(); idle();
    chk("clear_again", 32'(stack_err), 32'd0);

    push = 1; tick(); tick(); idle();
    chk("two_push", 32'(depth_cnt), 32'd2);
    push = 1; pop = 1; tick(); idle();
    chk("pushpop_cnt", 32'(depth_cnt), 32'd2);
    chk("pushpop_err", 32'(stack_err), 32'd1);
    chk("pushpop_live", 32'(psw_data), 32'h18);

    push = 1; tick();
    chk("burst_cnt", 32'(depth_cnt), 32'd3);
    reset = 1; #1;
    chk_reset("async_rst");
    idle(); tick(); reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
